// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//
// Walks a 3-input combinational unit through all eight input combinations
// and captures its response as an 8-bit truth table. Each combination is held
// for SETTLE+1 cycles and s is sampled on the last cycle of that slot.
// After the scan, the table is compared against a reference table.
//
// Parameters
//   SETTLE    wait cycles between driving a combination and sampling s (0..15)
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   start     scan request, only honoured while idle
//   expected  reference table, bit i = required s for {a,b,c}=i
//   s         response of the unit under scan
//   a, b, c   unit inputs, {a,b,c} = current index (0 when not scanning)
//   table_o   captured table, bit i = s sampled for {a,b,c}=i
//   ones      number of ones in table_o (0..8)
//   busy      high while a scan is in progress
//   done      one-cycle pulse when table_o/ones/match are final
//   match     table_o == expected, valid from done until the next start

module truth_table_scanner #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       s,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic [7:0] table_o,
    output logic [3:0] ones,
    output logic       busy,
    output logic       done,
    output logic       match
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    state_e     state_q;
    logic [2:0] idx_q;
    logic [3:0] settle_q;
    logic [7:0] table_q;
    logic [3:0] ones_q;
    logic       busy_q;
    logic       done_q;
    logic       match_q;

    logic       slot_last;

    assign slot_last = (settle_q == SETTLE_L);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            table_q  <= '0;
            ones_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= SCAN;
                        idx_q    <= '0;
                        settle_q <= '0;
                        table_q  <= '0;
                        ones_q   <= '0;
                        match_q  <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end

                SCAN: begin
                    if (slot_last) begin
                        table_q[idx_q] <= s;
                        // At most eight samples are taken, so this cannot pass 8.
                        ones_q   <= ones_q + {3'b000, s};
                        settle_q <= '0;
                        if (idx_q == 3'd7) begin
                            // Index wraps to 0 so a/b/c fall back to 0 with busy.
                            idx_q   <= '0;
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    match_q <= (table_q == expected);
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The index is only nonzero in SCAN, so the unit inputs come straight
    // from the index register.
    assign a       = idx_q[2];
    assign b       = idx_q[1];
    assign c       = idx_q[0];
    assign table_o = table_q;
    assign ones    = ones_q;
    assign busy    = busy_q;
    assign done    = done_q;

    // expected is only looked at during DONE. The comparison is shown directly
    // in that cycle and latched at its end, so it holds until the next start.
    assign match = (state_q == DONE) ? (table_q == expected) : match_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
module tb_truth_table_scanner;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Three scanners with SETTLE = 0, 1, 2 (SETTLE equals the instance number).
    logic       rst_v  [3];
    logic       st_v   [3];
    logic [7:0] exp_v  [3];
    logic       s_v    [3];
    int         mode_v [3];
    logic [7:0] tt_v   [3];

    logic       a_w    [3];
    logic       b_w    [3];
    logic       c_w    [3];
    logic [7:0] tbl_w  [3];
    logic [3:0] ones_w [3];
    logic       busy_w [3];
    logic       done_w [3];
    logic       match_w[3];

    int errors = 0;
    int checks = 0;

    // Behaviour of the unit under scan, expressed as gate logic on a/b/c.
    // 0: tie 0, 1: tie 1, 2: odd parity (SOP), 3: s=a, 4: s=c, 5: table lookup
    function automatic logic drive_s(int mode, logic [7:0] tt, logic a, logic b, logic c);
        logic [7:0] t;
        logic [2:0] i;
        t = tt;
        i = {a, b, c};
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return (a & ~b & ~c) | (~a & b & ~c) | (~a & ~b & c) | (a & b & c);
            3: return a;
            4: return c;
            default: return t[i];
        endcase
    endfunction

    // Reference: the response for combination number i, from arithmetic on i.
    function automatic bit model_bit(int mode, logic [7:0] tt, int i);
        logic [7:0] t;
        t = tt;
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return ((i / 4) + ((i / 2) % 2) + (i % 2)) % 2 == 1;
            3: return i >= 4;
            4: return i % 2 == 1;
            default: return t[i];
        endcase
    endfunction

    function automatic logic [7:0] model_table(int mode, logic [7:0] tt);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i] = model_bit(mode, tt, i);
        return r;
    endfunction

    always_comb s_v[0] = drive_s(mode_v[0], tt_v[0], a_w[0], b_w[0], c_w[0]);
    always_comb s_v[1] = drive_s(mode_v[1], tt_v[1], a_w[1], b_w[1], c_w[1]);
    always_comb s_v[2] = drive_s(mode_v[2], tt_v[2], a_w[2], b_w[2], c_w[2]);

    truth_table_scanner #(.SETTLE(0)) u_s0 (
        .clk(clk), .reset(rst_v[0]), .start(st_v[0]), .expected(exp_v[0]), .s(s_v[0]),
        .a(a_w[0]), .b(b_w[0]), .c(c_w[0]), .table_o(tbl_w[0]), .ones(ones_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .match(match_w[0])
    );
    truth_table_scanner #(.SETTLE(1)) u_s1 (
        .clk(clk), .reset(rst_v[1]), .start(st_v[1]), .expected(exp_v[1]), .s(s_v[1]),
        .a(a_w[1]), .b(b_w[1]), .c(c_w[1]), .table_o(tbl_w[1]), .ones(ones_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .match(match_w[1])
    );
    truth_table_scanner #(.SETTLE(2)) u_s2 (
        .clk(clk), .reset(rst_v[2]), .start(st_v[2]), .expected(exp_v[2]), .s(s_v[2]),
        .a(a_w[2]), .b(b_w[2]), .c(c_w[2]), .table_o(tbl_w[2]), .ones(ones_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .match(match_w[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk_idle_reset(input int k, input string tag);
        chk($sformatf("%s k%0d busy", tag, k), 32'(busy_w[k]), 32'd0);
        chk($sformatf("%s k%0d done", tag, k), 32'(done_w[k]), 32'd0);
        chk($sformatf("%s k%0d table", tag, k), 32'(tbl_w[k]), 32'd0);
        chk($sformatf("%s k%0d ones", tag, k), 32'(ones_w[k]), 32'd0);
        chk($sformatf("%s k%0d match", tag, k), 32'(match_w[k]), 32'd0);
        chk($sformatf("%s k%0d abc", tag, k), 32'({a_w[k], b_w[k], c_w[k]}), 32'd0);
    endtask

    // Full scan on instance k. expected carries garbage while scanning and is
    // made correct only for the DONE cycle, then scrambled again afterwards.
    // mid: extra start pulses mid-scan and during DONE, both must be ignored.
    // rel_rst: reset is dropped on the same edge start is raised.
    task automatic run_scan(input int k, input int mode, input logic [7:0] tt,
                            input logic [7:0] exp, input bit mid, input bit rel_rst,
                            input logic [7:0] wt, input logic [3:0] wo, input bit wm);
        int L;
        L = 8 * (k + 1);
        @(negedge clk);
        mode_v[k] = mode;
        tt_v[k]   = tt;
        exp_v[k]  = ~exp;
        st_v[k]   = 1'b1;
        if (rel_rst) rst_v[k] = 1'b0;
        for (int cyc = 0; cyc <= L + 2; cyc++) begin
            @(negedge clk);
            if (cyc < L) begin
                chk($sformatf("k%0d busy c%0d", k, cyc), 32'(busy_w[k]), 32'd1);
                chk($sformatf("k%0d done_early c%0d", k, cyc), 32'(done_w[k]), 32'd0);
                chk($sformatf("k%0d abc c%0d", k, cyc), 32'({a_w[k], b_w[k], c_w[k]}),
                    32'(cyc / (k + 1)));
            end else if (cyc == L) begin
                chk($sformatf("k%0d done", k), 32'(done_w[k]), 32'd1);
                chk($sformatf("k%0d busy_done", k), 32'(busy_w[k]), 32'd0);
                chk($sformatf("k%0d abc_done", k), 32'({a_w[k], b_w[k], c_w[k]}), 32'd0);
                chk($sformatf("k%0d table", k), 32'(tbl_w[k]), 32'(wt));
                chk($sformatf("k%0d ones", k), 32'(ones_w[k]), 32'(wo));
                chk($sformatf("k%0d match", k), 32'(match_w[k]), 32'(wm));
            end else if (cyc == L + 1) begin
                chk($sformatf("k%0d done_pulse", k), 32'(done_w[k]), 32'd0);
                chk($sformatf("k%0d busy_after", k), 32'(busy_w[k]), 32'd0);
                chk($sformatf("k%0d match_hold", k), 32'(match_w[k]), 32'(wm));
            end else begin
                chk($sformatf("k%0d no_requeue", k), 32'(busy_w[k]), 32'd0);
                chk($sformatf("k%0d table_hold", k), 32'(tbl_w[k]), 32'(wt));
                chk($sformatf("k%0d ones_hold", k), 32'(ones_w[k]), 32'(wo));
                chk($sformatf("k%0d match_hold2", k), 32'(match_w[k]), 32'(wm));
            end
            if (cyc == 0) st_v[k] = 1'b0;
            if (mid && (cyc == L / 2 || cyc == L)) st_v[k] = 1'b1;
            if (mid && (cyc == L / 2 + 1 || cyc == L + 1)) st_v[k] = 1'b0;
            if (cyc == L - 1) exp_v[k] = exp;
            if (cyc == L + 1) exp_v[k] = ~exp;
        end
    endtask

    typedef struct {
        int         k;
        int         mode;
        logic [7:0] exp;
        bit         mid;
        logic [7:0] w_tbl;
        logic [3:0] w_ones;
        bit         w_match;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{k: 1, mode: 0, exp: 8'h00, mid: 1'b0, w_tbl: 8'h00, w_ones: 4'd0, w_match: 1'b1};
        vecs[1] = '{k: 1, mode: 2, exp: 8'h96, mid: 1'b0, w_tbl: 8'h96, w_ones: 4'd4, w_match: 1'b1};
        vecs[2] = '{k: 0, mode: 3, exp: 8'hFF, mid: 1'b0, w_tbl: 8'hF0, w_ones: 4'd4, w_match: 1'b0};
        vecs[3] = '{k: 0, mode: 1, exp: 8'hFF, mid: 1'b0, w_tbl: 8'hFF, w_ones: 4'd8, w_match: 1'b1};
        vecs[4] = '{k: 2, mode: 4, exp: 8'hAA, mid: 1'b1, w_tbl: 8'hAA, w_ones: 4'd4, w_match: 1'b1};

        for (int k = 0; k < 3; k++) begin
            rst_v[k]  = 1'b1;
            st_v[k]   = 1'b0;
            exp_v[k]  = '0;
            mode_v[k] = 0;
            tt_v[k]   = '0;
        end
        // start held high on instance 0 throughout reset
        st_v[0] = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) chk_idle_reset(k, "reset");
        rst_v[1] = 1'b0;
        rst_v[2] = 1'b0;

        // Scan must begin on the first edge with reset low.
        run_scan(0, 3, 8'h00, 8'hFF, 1'b0, 1'b1, 8'hF0, 4'd4, 1'b0);

        for (int v = 0; v < 5; v++)
            run_scan(vecs[v].k, vecs[v].mode, 8'h00, vecs[v].exp, vecs[v].mid, 1'b0,
                     vecs[v].w_tbl, vecs[v].w_ones, vecs[v].w_match);

        // Reset during the seventh SCAN cycle of the SETTLE=1 scanner.
        @(negedge clk);
        mode_v[1] = 1;
        exp_v[1]  = 8'hFF;
        st_v[1]   = 1'b1;
        for (int cyc = 0; cyc < 7; cyc++) begin
            @(negedge clk);
            if (cyc == 0) st_v[1] = 1'b0;
            chk($sformatf("abort busy c%0d", cyc), 32'(busy_w[1]), 32'd1);
        end
        rst_v[1] = 1'b1;
        @(negedge clk);
        chk_idle_reset(1, "abort");
        rst_v[1] = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            chk($sformatf("abort no_done c%0d", cyc), 32'(done_w[1]), 32'd0);
            chk($sformatf("abort idle c%0d", cyc), 32'(busy_w[1]), 32'd0);
        end
        run_scan(1, 2, 8'h00, 8'h96, 1'b0, 1'b0, 8'h96, 4'd4, 1'b1);

        // Random truth tables against the reference model.
        for (int n = 0; n < 24; n++) begin
            int         k;
            logic [7:0] tt;
            logic [7:0] ex;
            logic [7:0] wt;
            k  = int'($urandom_range(0, 2));
            tt = 8'($urandom);
            wt = model_table(5, tt);
            ex = ($urandom_range(0, 1) == 1) ? wt : 8'($urandom);
            run_scan(k, 5, tt, ex, 1'($urandom_range(0, 1)), 1'b0,
                     wt, 4'($countones(wt)), wt == ex);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 Parameter: SETTLE, default 1, number of wait cycles between driving a combination and sampling s (legal 0..15).
REQ-002 Ports (one clock; reset is synchronous and active-high):
  clk       input   1  sole clock, rising-edge active
  reset     input   1  synchronous, active-high reset
  start     input   1  scan request, sampled in IDLE only
  expected  input   8  reference truth table, bit i = required s for {a,b,c}=i
  s         input   1  output of the 3-input combinational unit under scan
  a         output  1  unit input, MSB of current index
  b         output  1  unit input, middle bit of current index
  c         output  1  unit input, LSB of current index
  table     output  8  captured truth table, bit i = s sampled for {a,b,c}=i
  ones      output  4  popcount of table (0..8)
  busy      output  1  high while a scan is in progress
  done      output  1  one-cycle pulse when table/ones/match are final
  match     output  1  table == expected, valid from done until next accepted start

Function
REQ-003 FSM states: IDLE, SCAN, DONE; registered state, one-hot or binary at implementer's choice.
REQ-004 IDLE: start=1 -> SCAN next cycle; index<=0, settle counter<=0, table<=0, ones<=0, match<=0.
REQ-005 IDLE: start=0 -> stay; table, ones, match hold last values.
REQ-006 {a,b,c} SHALL be driven from a registered 3-bit index; a=index[2], b=index[1], c=index[0]; 0 outside SCAN.
REQ-007 SCAN: each index occupies exactly SETTLE+1 cycles; settle counter increments each cycle of the slot.
REQ-008 s SHALL be sampled into table[index] on the last cycle of the slot (settle counter == SETTLE); ones incremented by s in the same cycle.
REQ-009 On the sample of index 7, index wraps to 0 and FSM -> DONE; no ninth sample.
REQ-010 Scan length: 8*(SETTLE+1) cycles in SCAN; SETTLE=0 gives one sample per cycle.
REQ-011 busy=1 exactly in cycles where state==SCAN.
REQ-012 DONE: lasts one cycle; done=1; match<=(table==expected) using final table, visible in the DONE cycle; then -> IDLE.
REQ-013 start asserted during SCAN or DONE SHALL be ignored (not queued).
REQ-014 expected is sampled only in the DONE cycle; changes during SCAN have no effect.
REQ-015 ones SHALL never exceed 8; 4-bit width, no wrap.

Reset
REQ-016 reset=1 at a rising edge -> state IDLE, index 0, settle counter 0, a=b=c=0, table=0, ones=0, busy=0, done=0, match=0.
REQ-017 reset has priority over start and over any in-progress scan; reset mid-SCAN aborts with no done pulse.
REQ-018 start held high through reset release: scan starts on the first edge with reset=0.

Verification
REQ-019 SETTLE=1, s tied 0, start pulse -> busy high 16 cycles, done pulse next cycle, table=0x00, ones=0; expected=0x00 -> match=1.
REQ-020 SETTLE=1, s driven by a 3-input NOR-based SOP for odd parity (s=a^b^c), expected=0x96 -> table=0x96, ones=4, match=1.
REQ-021 SETTLE=0, s=a, expected=0xFF -> busy 8 cycles, table=0xF0, ones=4, match=0; s tied 1 on rerun -> table=0xFF, ones=8, match=1.
REQ-022 SETTLE=2, s=c, start re-pulsed mid-scan -> ignored; single done after 24 SCAN cycles, table=0xAA.
REQ-023 SETTLE=1, reset asserted at SCAN cycle 7 -> next cycle busy=0, table=0, ones=0, a=b=c=0, no done; fresh start completes normally.
REQ-024 Every slot: assert {a,b,c} stable for SETTLE+1 cycles and index order 0..7 monotonic.
